// File: rtl/lcd_pkg.sv
// Shared types, colour-bar table and raster-span helpers for the LCD scan path.
package lcd_pkg;

  localparam int DAT_WIDTH = 24;
  typedef logic [DAT_WIDTH-1:0] pixel_t;

  localparam pixel_t BAR_COLORS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // Line/frame length in pixels or lines (H_TOTAL / V_TOTAL).
  function automatic int span_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Sync region is [active+fp, active+fp+sync), compared at 32 bits so the
  // upper bound may equal the counter's full range.
  function automatic logic in_sync(input int unsigned cnt, input int unsigned active,
                                   input int unsigned fp, input int unsigned sync);
    return (cnt >= active + fp) && (cnt < active + fp + sync);
  endfunction

endpackage

// File: rtl/lcd_timing_gen.sv
// Pixel divider, h/v raster counters and region decode for lcd_scan.
// With LCD_SCAN_TEST_PATTERN_EN the horizontal count is exported for the bar generator.
module lcd_timing_gen
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE = 32,
  parameter int H_FP     = 2,
  parameter int H_SYNC   = 4,
  parameter int H_BP     = 2,
  parameter int V_ACTIVE = 32,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 1,
  parameter int CLK_DIV  = 4,
  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL),
  localparam int DW      = $clog2(CLK_DIV)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable_i,
  output logic          tick_o,
  output logic          active_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic          frame_start_o,
  output logic          frame_end_o,
`ifdef LCD_SCAN_TEST_PATTERN_EN
  output logic [HW-1:0] h_cnt_o,
`endif
  output logic          pclk_o
);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

  logic          run_q, run_d;
  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          pclk_q, pclk_d;
  logic          tick;

  // run_q delays the start by one clock so a fresh frame begins the clock
  // after enable is first seen; dropping enable clears everything at once.
  always_comb begin
    run_d   = enable_i;
    div_d   = '0;
    h_cnt_d = '0;
    v_cnt_d = '0;
    tick    = run_q && enable_i && (div_q == '0);
    if (run_q && enable_i) begin
      div_d   = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (tick) begin
        if (h_cnt_q == H_LAST) begin
          h_cnt_d = '0;
          v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end else begin
          h_cnt_d = h_cnt_q + 1'b1;
        end
      end
    end
    pclk_d = run_d && !((div_d != '0) && (div_d <= DIV_HALF));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q   <= 1'b0;
      div_q   <= '0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      pclk_q  <= 1'b0;
    end else begin
      run_q   <= run_d;
      div_q   <= div_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      pclk_q  <= pclk_d;
    end
  end

  assign tick_o        = tick;
  assign active_o      = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
  assign hs_o          = in_sync(32'(h_cnt_q), H_ACTIVE, H_FP, H_SYNC);
  assign vs_o          = in_sync(32'(v_cnt_q), V_ACTIVE, V_FP, V_SYNC);
  assign frame_start_o = tick && (h_cnt_q == '0) && (v_cnt_q == '0);
  assign frame_end_o   = tick && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
  assign pclk_o        = pclk_q;
`ifdef LCD_SCAN_TEST_PATTERN_EN
  assign h_cnt_o       = h_cnt_q;
`endif

endmodule

// File: rtl/lcd_scan.sv
// Framebuffer reader + LCD raster output: address counter, port-B read strobe, 2-stage pixel pipeline.
// Optional colour-bar generator enabled by LCD_SCAN_TEST_PATTERN_EN (adds input test_pattern).
module lcd_scan
  import lcd_pkg::*;
#(
  parameter int adr_width = 10,
  parameter int dat_width = 24,
  parameter int H_ACTIVE  = 32,
  parameter int H_FP      = 2,
  parameter int H_SYNC    = 4,
  parameter int H_BP      = 2,
  parameter int V_ACTIVE  = 32,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 1,
  parameter int CLK_DIV   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
`ifdef LCD_SCAN_TEST_PATTERN_EN
  input  logic                 test_pattern,
`endif
  output logic                 en_b,
  output logic [adr_width-1:0] adr_b,
  input  logic [dat_width-1:0] dat_b,
  output logic                 lcd_pclk,
  output logic                 lcd_hsync_n,
  output logic                 lcd_vsync_n,
  output logic                 lcd_de,
  output logic [dat_width-1:0] lcd_rgb,
  output logic                 frame_start
);

  logic tick, active, hs, vs, frame_end;

`ifdef LCD_SCAN_TEST_PATTERN_EN
  localparam int HW = $clog2(span_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  logic [HW-1:0] h_cnt;
`endif

  lcd_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CLK_DIV  (CLK_DIV)
  ) u_tg (
    .clk           (clk),
    .reset         (reset),
    .enable_i      (enable),
    .tick_o        (tick),
    .active_o      (active),
    .hs_o          (hs),
    .vs_o          (vs),
    .frame_start_o (frame_start),
    .frame_end_o   (frame_end),
`ifdef LCD_SCAN_TEST_PATTERN_EN
    .h_cnt_o       (h_cnt),
`endif
    .pclk_o        (lcd_pclk)
  );

  logic [adr_width-1:0] addr_q, addr_d;
  logic                 valid1_q, de1_q, hs1_q, vs1_q;
  logic [dat_width-1:0] pix_d;

  always_comb begin
    addr_d = addr_q;
    if (!enable || frame_end) begin
      addr_d = '0;
    end else if (tick && active) begin
      addr_d = addr_q + 1'b1;
    end
  end

`ifdef LCD_SCAN_TEST_PATTERN_EN
  // Bar index = h*8/H_ACTIVE as a thermometer of threshold compares.
  logic [6:0] bar_ge;
  logic [2:0] bar_idx;
  logic       pat1_q;
  logic [2:0] bar1_q;

  for (genvar gi = 1; gi < 8; gi++) begin : g_bar
    assign bar_ge[gi-1] = (32'(h_cnt) << 3) >= 32'(gi * H_ACTIVE);
  end
  assign bar_idx = 3'($countones(bar_ge));
  assign en_b    = tick && active && !test_pattern;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      pat1_q <= 1'b0;
      bar1_q <= '0;
    end else begin
      pat1_q <= test_pattern;
      bar1_q <= bar_idx;
    end
  end
`else
  assign en_b = tick && active;
`endif

  assign adr_b = addr_q;

  always_comb begin
    pix_d = '0;
    if (de1_q) begin
      pix_d = dat_b;
`ifdef LCD_SCAN_TEST_PATTERN_EN
      if (pat1_q) pix_d = dat_width'(BAR_COLORS[bar1_q]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  // Stage 1 lines the decode up with dat_b; stage 2 loads only one clock
  // after a tick, so the panel sees each pixel held for a full CLK_DIV.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      valid1_q    <= 1'b0;
      de1_q       <= 1'b0;
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
      lcd_de      <= 1'b0;
      lcd_rgb     <= '0;
      lcd_hsync_n <= 1'b1;
      lcd_vsync_n <= 1'b1;
    end else begin
      valid1_q <= tick;
      de1_q    <= active;
      hs1_q    <= hs;
      vs1_q    <= vs;
      if (valid1_q) begin
        lcd_de      <= de1_q;
        lcd_rgb     <= pix_d;
        lcd_hsync_n <= !hs1_q;
        lcd_vsync_n <= !vs1_q;
      end
    end
  end

endmodule

// File: tb/tb_lcd_scan.sv
// Directed scoreboard bench for lcd_scan with default parameters.
module tb_lcd_scan;

  localparam int HT    = 40;
  localparam int VT    = 36;
  localparam int DIV   = 4;
  localparam int FRAME = HT * VT * DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        en_b;
  logic [9:0]  adr_b;
  logic [23:0] dat_b = '0;
  logic        lcd_pclk, lcd_hsync_n, lcd_vsync_n, lcd_de, frame_start;
  logic [23:0] lcd_rgb;
`ifdef LCD_SCAN_TEST_PATTERN_EN
  logic        test_pattern = 1'b0;
`endif

  always #5 clk = ~clk;

  lcd_scan dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
`ifdef LCD_SCAN_TEST_PATTERN_EN
    .test_pattern (test_pattern),
`endif
    .en_b         (en_b),
    .adr_b        (adr_b),
    .dat_b        (dat_b),
    .lcd_pclk     (lcd_pclk),
    .lcd_hsync_n  (lcd_hsync_n),
    .lcd_vsync_n  (lcd_vsync_n),
    .lcd_de       (lcd_de),
    .lcd_rgb      (lcd_rgb),
    .frame_start  (frame_start)
  );

  // Framebuffer port B: one-clock read latency, contents = address ^ 0xA50000.
  always @(posedge clk) begin
    if (en_b) dat_b <= 24'(adr_b) ^ 24'hA50000;
  end

  typedef struct {
    int          due;
    logic        de;
    logic        hs_n;
    logic        vs_n;
    logic [23:0] rgb;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_e;
  bit   have_last = 0;
  bit   model_on  = 0;
  bit   tp_mode   = 0;
  int   mc        = 0;
  int   strobes   = 0;
  int   total     = 0;
  int   bad       = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s mc=%0d observed=%h expected=%h", tag, mc, obs, expv);
    end
  endtask

  function automatic logic [23:0] bar_color(input int h);
    case (h / 4)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // mc counts clocks since the first running clock (the expected frame_start).
  task automatic model_cycle();
    int   k, h, v;
    bit   act;
    exp_t e;
    check("pclk", lcd_pclk, ((mc % DIV) == 1 || (mc % DIV) == 2) ? 0 : 1);
    if (mc % DIV == 0) begin
      k   = mc / DIV;
      h   = k % HT;
      v   = (k / HT) % VT;
      act = (h < 32) && (v < 32);
      check("frame_start", frame_start, (h == 0 && v == 0));
      check("en_b", en_b, act && !tp_mode);
      if (act) check("adr_b", adr_b, v * 32 + h);
      if (en_b) strobes++;
      e.due  = mc + 2;
      e.de   = act;
      e.hs_n = !(h >= 34 && h < 38);
      e.vs_n = !(v >= 33 && v < 35);
      e.rgb  = !act ? 24'h0 : (tp_mode ? bar_color(h) : 24'((v * 32 + h) ^ 32'hA50000));
      exp_q.push_back(e);
    end else begin
      check("en_b_idle", en_b, 0);
      check("frame_start_idle", frame_start, 0);
    end
    if (exp_q.size() > 0 && exp_q[0].due == mc) begin
      e = exp_q.pop_front();
      check("lcd_de", lcd_de, e.de);
      check("lcd_rgb", lcd_rgb, e.rgb);
      check("hsync_n", lcd_hsync_n, e.hs_n);
      check("vsync_n", lcd_vsync_n, e.vs_n);
      last_e    = e;
      have_last = 1;
    end else if (have_last) begin
      check("hold_de", lcd_de, last_e.de);
      check("hold_rgb", lcd_rgb, last_e.rgb);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (model_on) begin
      mc++;
      model_cycle();
    end
  endtask

  task automatic model_stop();
    model_on  = 0;
    have_last = 0;
    exp_q.delete();
  endtask

  task automatic model_start();
    exp_q.delete();
    have_last = 0;
    mc        = -1;
    model_on  = 1;
  endtask

  task automatic blank_check(input string tag);
    check({tag, "_en_b"}, en_b, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_de"}, lcd_de, 0);
    check({tag, "_rgb"}, lcd_rgb, 0);
    check({tag, "_hsync_n"}, lcd_hsync_n, 1);
    check({tag, "_vsync_n"}, lcd_vsync_n, 1);
    check({tag, "_pclk"}, lcd_pclk, 0);
  endtask

  task automatic counters_zero(input string tag);
    check({tag, "_div"}, 32'(dut.u_tg.div_q), 0);
    check({tag, "_h"}, 32'(dut.u_tg.h_cnt_q), 0);
    check({tag, "_v"}, 32'(dut.u_tg.v_cnt_q), 0);
    check({tag, "_addr"}, 32'(dut.addr_q), 0);
  endtask

  initial begin
    // Reset state with enable already high.
    step();
    step();
    blank_check("reset");
    counters_zero("reset");

    // Release: frame_start on the first clock after reset is seen low.
    reset = 1'b0;
    model_start();
    strobes = 0;
    while (mc < FRAME - 1) step();
    check("strobes_per_frame", strobes, 1024);

    // Second frame until line 10, pixel 5 tick, then drop enable.
    while (mc < FRAME + (10 * HT + 5) * DIV) step();
    enable = 1'b0;
    model_stop();
    step();
    blank_check("disable");
    counters_zero("disable");
    step();
    step();
    blank_check("disabled");

    // Re-enable: fresh frame, address restarts at 0.
    enable = 1'b1;
    model_start();
    while (mc < 2 * HT * DIV + 50) step();

    // Reset pulse mid-line with enable held high.
    reset = 1'b1;
    model_stop();
    step();
    blank_check("midreset");
    counters_zero("midreset");
    step();
    blank_check("midreset2");
    reset = 1'b0;
    model_start();
    while (mc < 2 * HT * DIV) step();

`ifdef LCD_SCAN_TEST_PATTERN_EN
    // Colour bars: no framebuffer reads, bars of H_ACTIVE/8 pixels.
    enable = 1'b0;
    model_stop();
    step();
    blank_check("tp_off");
    test_pattern = 1'b1;
    tp_mode      = 1;
    enable       = 1'b1;
    model_start();
    while (mc < 2 * HT * DIV) step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
